// File: rtl/decode3_8bits_if.sv
// Bus bundle for decode3_8bits.
//   W     : 3-bit code to decode (master -> slave)
//   En    : decoder enable, active-high (master -> slave)
//   Y     : combinational one-hot decode (slave -> master)
//   Yq    : registered copy of Y (slave -> master)
//   Valid : registered En, qualifies Yq (slave -> master)
interface decode3_8bits_if;
  logic [2:0] W;
  logic       En;
  logic [7:0] Y;
  logic [7:0] Yq;
  logic       Valid;

  modport master (
    output W,
    output En,
    input  Y,
    input  Yq,
    input  Valid
  );

  modport slave (
    input  W,
    input  En,
    output Y,
    output Yq,
    output Valid
  );
endinterface

// File: rtl/decode3_8bits.sv
// 3-to-8 one-hot decoder with an enable, a combinational output and a
// one-cycle registered copy.
//   MSB_FIRST : 1 -> code 0 drives Y[7]; 0 -> code 0 drives Y[0]
//   Clock     : rising-edge system clock
//   Resetn    : asynchronous active-low reset of Yq/Valid
//   bus       : decode3_8bits_if slave (W, En in; Y, Yq, Valid out)
module decode3_8bits #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           Clock,
  input  logic           Resetn,
  decode3_8bits_if.slave bus
);

  localparam int unsigned OUT_W = 8;

  logic [OUT_W-1:0] w_onehot_lsb;
  logic [OUT_W-1:0] w_y;
  logic [OUT_W-1:0] r_yq;
  logic             r_valid;

  // LSB-first decode; an unknown code or a disabled decoder yields all-zero.
  always_comb begin
    w_onehot_lsb = '0;
    if (bus.En) begin
      case (bus.W)
        3'd0:    w_onehot_lsb = 8'b0000_0001;
        3'd1:    w_onehot_lsb = 8'b0000_0010;
        3'd2:    w_onehot_lsb = 8'b0000_0100;
        3'd3:    w_onehot_lsb = 8'b0000_1000;
        3'd4:    w_onehot_lsb = 8'b0001_0000;
        3'd5:    w_onehot_lsb = 8'b0010_0000;
        3'd6:    w_onehot_lsb = 8'b0100_0000;
        3'd7:    w_onehot_lsb = 8'b1000_0000;
        default: w_onehot_lsb = '0;
      endcase
    end
  end

  // Output bit ordering, fixed at elaboration.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_order
    if (MSB_FIRST) begin : g_msb
      assign w_y[gi] = w_onehot_lsb[OUT_W-1-gi];
    end else begin : g_lsb
      assign w_y[gi] = w_onehot_lsb[gi];
    end
  end

  // Registered copy; reset discards any held code.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_yq    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_yq    <= w_y;
      r_valid <= bus.En;
    end
  end

  assign bus.Y     = w_y;
  assign bus.Yq    = r_yq;
  assign bus.Valid = r_valid;

endmodule

// File: tb/tb_decode3_8bits.sv
// Self-checking bench for decode3_8bits: one MSB-first and one LSB-first
// instance share the clock/reset; registered results are tracked in a
// scoreboard queue filled when a code is driven.
module tb_decode3_8bits;

  typedef struct packed {
    logic [7:0] yq_m;
    logic [7:0] yq_l;
    logic       valid;
  } exp_t;

  logic Clock;
  logic Resetn;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  decode3_8bits_if bm();
  decode3_8bits_if bl();

  decode3_8bits #(.MSB_FIRST(1'b1)) dut_m (.Clock(Clock), .Resetn(Resetn), .bus(bm));
  decode3_8bits #(.MSB_FIRST(1'b0)) dut_l (.Clock(Clock), .Resetn(Resetn), .bus(bl));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [7:0] model_y(input logic [2:0] w, input logic en, input bit msb);
    logic [7:0] v;
    if (!en) return 8'h00;
    v = msb ? (8'h80 >> w) : (8'h01 << w);
    return v;
  endfunction

  // Drive both instances and record what the next edge must register.
  task automatic drive(input logic [2:0] w, input logic en);
    exp_t e;
    bm.W = w; bm.En = en;
    bl.W = w; bl.En = en;
    e.yq_m  = model_y(w, en, 1'b1);
    e.yq_l  = model_y(w, en, 1'b0);
    e.valid = en;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    Resetn = 1'b0;
    sb_q.delete();
    bm.W = 3'd2; bm.En = 1'b1; bl.W = 3'd2; bl.En = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if (bm.Yq !== 8'h00 || bm.Valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_m: Yq=%b Valid=%b want 00000000/0", bm.Yq, bm.Valid);
    end
    n_checks++;
    if (bl.Yq !== 8'h00 || bl.Valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_l: Yq=%b Valid=%b want 00000000/0", bl.Yq, bl.Valid);
    end
    n_checks++;
    if (bm.Y !== 8'b0010_0000 || bl.Y !== 8'b0000_0100) begin
      n_fail++; $display("FAIL reset_comb_y: Ym=%b Yl=%b want 00100000/00000100", bm.Y, bl.Y);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    drive(3'd2, 1'b1);
    @(posedge Clock); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bm.Yq !== e.yq_m || bm.Valid !== e.valid || bl.Yq !== e.yq_l) begin
      n_fail++; $display("FAIL reset_first_load: Yqm=%b Yql=%b V=%b want %b/%b/%b",
                         bm.Yq, bl.Yq, bm.Valid, e.yq_m, e.yq_l, e.valid);
    end
  endtask

  task automatic test_msb_sweep();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      drive(3'(i), 1'b1);
      #1;
      n_checks++;
      if (bm.Y !== (8'h80 >> i)) begin
        n_fail++; $display("FAIL msb_sweep_y w=%0d: Y=%b want %b", i, bm.Y, 8'h80 >> i);
      end
      @(posedge Clock); #1;
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL msb_sweep_sb: queue empty");
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (bm.Yq !== e.yq_m || bm.Valid !== 1'b1) begin
          n_fail++; $display("FAIL msb_sweep_yq w=%0d: Yq=%b V=%b want %b/1", i, bm.Yq, bm.Valid, e.yq_m);
        end
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    @(negedge Clock);
    drive(3'b101, 1'b0);
    #1;
    n_checks++;
    if (bm.Y !== 8'h00 || bl.Y !== 8'h00) begin
      n_fail++; $display("FAIL disable_y: Ym=%b Yl=%b want 00000000", bm.Y, bl.Y);
    end
    @(posedge Clock); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bm.Yq !== e.yq_m || bm.Valid !== e.valid || bl.Yq !== e.yq_l || bl.Valid !== e.valid) begin
      n_fail++; $display("FAIL disable_yq: Yqm=%b Yql=%b V=%b want 00000000/0", bm.Yq, bl.Yq, bm.Valid);
    end
  endtask

  task automatic test_midcycle();
    exp_t e;
    @(negedge Clock);
    drive(3'd0, 1'b1);
    @(posedge Clock); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bm.Yq !== e.yq_m) begin
      n_fail++; $display("FAIL midcycle_load: Yq=%b want %b", bm.Yq, e.yq_m);
    end
    #1;
    drive(3'd7, 1'b1);
    #1;
    n_checks++;
    if (bm.Y !== 8'b0000_0001 || bm.Yq !== 8'b1000_0000) begin
      n_fail++; $display("FAIL midcycle_change: Y=%b Yq=%b want 00000001/10000000", bm.Y, bm.Yq);
    end
    @(posedge Clock); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bm.Yq !== e.yq_m || bl.Yq !== e.yq_l) begin
      n_fail++; $display("FAIL midcycle_next: Yqm=%b Yql=%b want %b/%b", bm.Yq, bl.Yq, e.yq_m, e.yq_l);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge Clock);
    drive(3'd1, 1'b1);
    @(posedge Clock); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bm.Yq !== e.yq_m || bm.Valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_load: Yq=%b V=%b want %b/1", bm.Yq, bm.Valid, e.yq_m);
    end
    #1;
    Resetn = 1'b0;
    #1;
    n_checks++;
    if (bm.Yq !== 8'h00 || bm.Valid !== 1'b0 || bl.Yq !== 8'h00 || bl.Valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: Yqm=%b Yql=%b V=%b want 0/0/0", bm.Yq, bl.Yq, bm.Valid);
    end
    n_checks++;
    if (bm.Y !== 8'b0100_0000) begin
      n_fail++; $display("FAIL rstmid_comb_y: Y=%b want 01000000", bm.Y);
    end
    @(posedge Clock); #1;
    n_checks++;
    if (bm.Yq !== 8'h00 || bm.Valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold: Yq=%b V=%b want 0/0", bm.Yq, bm.Valid);
    end
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_lsb_first();
    logic [2:0] codes [2];
    exp_t e;
    codes[0] = 3'b000;
    codes[1] = 3'b110;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      drive(codes[i], 1'b1);
      #1;
      n_checks++;
      if (bl.Y !== model_y(codes[i], 1'b1, 1'b0)) begin
        n_fail++; $display("FAIL lsb_y w=%0d: Y=%b want %b", codes[i], bl.Y, model_y(codes[i], 1'b1, 1'b0));
      end
      @(posedge Clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bl.Yq !== e.yq_l || bl.Valid !== 1'b1) begin
        n_fail++; $display("FAIL lsb_yq w=%0d: Yq=%b V=%b want %b/1", codes[i], bl.Yq, bl.Valid, e.yq_l);
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int en = 0; en < 2; en++) begin
      for (int w = 0; w < 8; w++) begin
        bm.W = 3'(w); bm.En = 1'(en); bl.W = 3'(w); bl.En = 1'(en);
        #1;
        n_checks++;
        if ($countones(bm.Y) != en || $countones(bl.Y) != en) begin
          n_fail++; $display("FAIL exh_onehot en=%0d w=%0d: Ym=%b Yl=%b want %0d bits", en, w, bm.Y, bl.Y, en);
        end
        n_checks++;
        if (bm.Y !== model_y(3'(w), 1'(en), 1'b1) || bl.Y !== model_y(3'(w), 1'(en), 1'b0)) begin
          n_fail++; $display("FAIL exh_value en=%0d w=%0d: Ym=%b Yl=%b", en, w, bm.Y, bl.Y);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] w;
    logic       en;
    exp_t       e;
    sb_q.delete();
    @(negedge Clock);
    for (int i = 0; i < 20; i++) begin
      w  = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 3) != 0);
      drive(w, en);
      @(posedge Clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bm.Yq !== e.yq_m || bl.Yq !== e.yq_l || bm.Valid !== e.valid || bl.Valid !== e.valid) begin
        n_fail++; $display("FAIL b2b cyc=%0d: Yqm=%b Yql=%b V=%b want %b/%b/%b",
                           i, bm.Yq, bl.Yq, bm.Valid, e.yq_m, e.yq_l, e.valid);
      end
      n_checks++;
      if (bm.Valid === 1'b0 && bm.Yq !== 8'h00) begin
        n_fail++; $display("FAIL b2b_zero cyc=%0d: Yq=%b with Valid=0", i, bm.Yq);
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Resetn   = 1'b0;
    bm.W = 3'd0; bm.En = 1'b0;
    bl.W = 3'd0; bl.En = 1'b0;
    test_reset();
    test_msb_sweep();
    test_disable();
    test_midcycle();
    test_reset_mid();
    test_lsb_first();
    test_exhaustive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode3_8bits.md
DECODE3_8BITS -- requirements
Module: decode3_8bits

Interface
REQ-001 Parameter MSB_FIRST, default 1, bit ordering: 1 = code 0 drives Y[7]; 0 = code 0 drives Y[0].
REQ-002 Clock  input  1  single system clock, rising-edge active.
REQ-003 Resetn  input  1  asynchronous active-low reset.
REQ-004 W  input  3  binary code to decode (register-field selector).
REQ-005 En  input  1  decoder enable, active-high.
REQ-006 Y  output  8  combinational one-hot decode of W, gated by En.
REQ-007 Yq  output  8  registered copy of Y.
REQ-008 Valid  output  1  registered En; high when Yq holds an enabled decode.

Function
REQ-009 Y SHALL be purely combinational from W and En, with zero-cycle latency and no dependence on Clock or Resetn.
REQ-010 With En=1 and MSB_FIRST=1, Y SHALL have exactly bit (7-W) set: 000->1000_0000, 001->0100_0000, 010->0010_0000, 011->0001_0000, 100->0000_1000, 101->0000_0100, 110->0000_0010, 111->0000_0001.
REQ-011 With En=1 and MSB_FIRST=0, Y SHALL have exactly bit W set (000->0000_0001 ... 111->1000_0000).
REQ-012 With En=0, Y SHALL be 8'b0000_0000 regardless of W.
REQ-013 Y SHALL never have more than one bit set for any W/En combination.
REQ-014 Any X/Z on W while En=1 SHALL drive Y to all-zero (no partial one-hot).
REQ-015 On each rising Clock edge with Resetn=1, Yq SHALL load the current Y and Valid SHALL load the current En (one-cycle latency).
REQ-016 Yq SHALL equal 0 whenever Valid=0, and SHALL be one-hot whenever Valid=1.
REQ-017 W or En changes between clock edges SHALL affect Y immediately and Yq/Valid only at the next rising edge.
REQ-018 Back-to-back codes on consecutive cycles SHALL each appear on Yq exactly one cycle later, with no dropped or merged codes.

Reset
REQ-019 Resetn=0 SHALL asynchronously force Yq=8'b0 and Valid=0, without waiting for a clock edge.
REQ-020 While Resetn=0, Yq and Valid SHALL hold 0 across clock edges; Y SHALL keep decoding combinationally.
REQ-021 After Resetn deasserts, the first rising edge SHALL load Yq/Valid normally; a reset asserted mid-operation SHALL discard the registered code.

Verification
REQ-022 MSB_FIRST=1, En=1, sweep W=0..7 -> Y = 1000_0000, 0100_0000, ... , 0000_0001; Yq matches one cycle later with Valid=1.
REQ-023 En=0, W=3'b101 -> Y=0000_0000; after the next edge Yq=0000_0000, Valid=0.
REQ-024 Y=0100_0000 registered (W=001, En=1), then Resetn pulsed low between edges -> Yq=0 and Valid=0 immediately; Y remains 0100_0000.
REQ-025 W changes 000->111 mid-cycle with En=1 -> Y switches at once to 0000_0001; Yq stays 1000_0000 until the next edge.
REQ-026 MSB_FIRST=0, En=1, W=3'b000 and W=3'b110 -> Y=0000_0001 and Y=0100_0000 respectively.
REQ-027 Exhaustive 16-case W/En sweep -> $countones(Y) is at most 1, and equals 1 only when En=1.
